// File: rtl/spi_pll_cfg_sequencer.sv
// SPI command sequencer for the PLL slave: deserialises 16-bit frames, executes
// register writes/reads, FIFO streaming and error handling, and queues the reply.
module spi_pll_cfg_sequencer #(
    parameter int         NUM_REGS  = 8,
    parameter logic [7:0] CFG_RESET = 8'h00
) (
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [15:0]           fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_pop,
    output logic [NUM_REGS*8-1:0] cfg_regs,
    output logic                  cfg_wr_strobe,
    output logic [3:0]            cfg_wr_addr,
    output logic                  err_flag,
    output logic [7:0]            frame_count
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [3:0]  OP_NOP    = 4'h0;
    localparam logic [3:0]  OP_WRITE  = 4'h1;
    localparam logic [3:0]  OP_READ   = 4'h2;
    localparam logic [3:0]  OP_STREAM = 4'h3;
    localparam logic [3:0]  OP_CLEAR  = 4'h4;
    localparam logic [15:0] RESP_ERR  = 16'hDEAD;

    state_t      state_q;
    logic [3:0]  bit_cnt_q;
    logic [15:0] rx_shift_q;
    logic [15:0] resp_shift_q;
    logic [7:0]  cfg_q [NUM_REGS];
    logic        fifo_pop_q;
    logic        cfg_wr_strobe_q;
    logic [3:0]  cfg_wr_addr_q;
    logic        err_flag_q;
    logic [7:0]  frame_count_q;

    logic [15:0] frame_d;
    logic [3:0]  opcode;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic        addr_ok;
    logic        frame_done;
    logic [7:0]  rd_data;
    logic [15:0] resp_d;
    logic        wr_en;
    logic        pop_en;
    logic        err_set;
    logic        err_clr;

    // The bit sampled on the completing edge is still on mosi, not in rx_shift.
    assign frame_d    = {rx_shift_q[14:0], mosi};
    assign opcode     = frame_d[15:12];
    assign addr       = frame_d[11:8];
    assign data       = frame_d[7:0];
    assign addr_ok    = ({1'b0, addr} < 5'(NUM_REGS));
    assign frame_done = (state_q == SHIFT) && !ss && (bit_cnt_q == 4'd15);

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == 4'(i)) rd_data = cfg_q[i];
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        resp_d  = 16'h0000;
        wr_en   = 1'b0;
        pop_en  = 1'b0;
        err_set = 1'b0;
        err_clr = 1'b0;
        case (opcode)
            OP_NOP: resp_d = 16'h0000;
            OP_WRITE: begin
                if (addr_ok) begin
                    wr_en  = 1'b1;
                    resp_d = {OP_WRITE, addr, data};
                end else begin
                    err_set = 1'b1;
                    resp_d  = RESP_ERR;
                end
            end
            OP_READ: begin
                if (addr_ok) begin
                    resp_d = {OP_READ, addr, rd_data};
                end else begin
                    err_set = 1'b1;
                    resp_d  = RESP_ERR;
                end
            end
            OP_STREAM: begin
                if (fifo_valid) begin
                    pop_en = 1'b1;
                    resp_d = fifo_data;
                end else begin
                    err_set = 1'b1;
                end
            end
            OP_CLEAR: begin
                err_clr = 1'b1;
                resp_d  = {15'h0000, err_flag_q};
            end
            default: begin
                err_set = 1'b1;
                resp_d  = RESP_ERR;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // sees the pre-edge value of every other flop.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= 4'd0;
            rx_shift_q      <= 16'h0000;
            resp_shift_q    <= 16'h0000;
            fifo_pop_q      <= 1'b0;
            cfg_wr_strobe_q <= 1'b0;
            cfg_wr_addr_q   <= 4'd0;
            err_flag_q      <= 1'b0;
            frame_count_q   <= 8'd0;
            // NOTE: the register bank is small, software-visible state, so it is
            // reset explicitly rather than left as uninitialised storage.
            for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= CFG_RESET;
        end else begin
            fifo_pop_q      <= 1'b0;
            cfg_wr_strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!ss) begin
                        rx_shift_q   <= frame_d;
                        resp_shift_q <= {resp_shift_q[14:0], 1'b0};
                        bit_cnt_q    <= 4'd1;
                        state_q      <= SHIFT;
                    end else begin
                        bit_cnt_q <= 4'd0;
                    end
                end
                SHIFT: begin
                    if (ss) begin
                        bit_cnt_q    <= 4'd0;
                        resp_shift_q <= 16'h0000;
                        state_q      <= IDLE;
                    end else if (frame_done) begin
                        rx_shift_q      <= frame_d;
                        resp_shift_q    <= resp_d;
                        bit_cnt_q       <= 4'd0;
                        state_q         <= IDLE;
                        frame_count_q   <= frame_count_q + 8'd1;
                        fifo_pop_q      <= pop_en;
                        cfg_wr_strobe_q <= wr_en;
                        if (wr_en) cfg_wr_addr_q <= addr;
                        if (err_set) err_flag_q <= 1'b1;
                        else if (err_clr) err_flag_q <= 1'b0;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (wr_en && addr == 4'(i)) cfg_q[i] <= data;
                        end
                    end else begin
                        rx_shift_q   <= frame_d;
                        resp_shift_q <= {resp_shift_q[14:0], 1'b0};
                        bit_cnt_q    <= bit_cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign cfg_regs[8*g +: 8] = cfg_q[g];
        end
    endgenerate

    assign miso          = resp_shift_q[15];
    assign fifo_pop      = fifo_pop_q;
    assign cfg_wr_strobe = cfg_wr_strobe_q;
    assign cfg_wr_addr   = cfg_wr_addr_q;
    assign err_flag      = err_flag_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_spi_pll_cfg_sequencer.sv
// Self-checking bench: directed scenarios then random frames, each compared with
// a transaction-level model of the register bank, error flag and reply queue.
module tb_spi_pll_cfg_sequencer;

    localparam int         NR = 8;
    localparam logic [7:0] CR = 8'h3C;

    logic            rst, sclk, ss, mosi, miso;
    logic [15:0]     fifo_data;
    logic            fifo_valid, fifo_pop;
    logic [NR*8-1:0] cfg_regs;
    logic            cfg_wr_strobe;
    logic [3:0]      cfg_wr_addr;
    logic            err_flag;
    logic [7:0]      frame_count;

    spi_pll_cfg_sequencer #(.NUM_REGS(NR), .CFG_RESET(CR)) dut (
        .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_pop(fifo_pop),
        .cfg_regs(cfg_regs), .cfg_wr_strobe(cfg_wr_strobe),
        .cfg_wr_addr(cfg_wr_addr), .err_flag(err_flag), .frame_count(frame_count)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  m_regs [16];
    logic        m_err;
    logic [7:0]  m_fc;
    logic [3:0]  m_wr_addr;
    logic [15:0] m_resp;
    int          m_strobes, m_pops;
    int          seen_strobes = 0, seen_pops = 0;

    always @(posedge sclk) begin
        if (cfg_wr_strobe) seen_strobes++;
        if (fifo_pop) seen_pops++;
    end

    function automatic logic [63:0] m_flat();
        logic [63:0] r = '0;
        for (int i = 0; i < NR; i++) r[8*i +: 8] = m_regs[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = CR;
        m_err = 1'b0; m_fc = 8'd0; m_wr_addr = 4'd0; m_resp = 16'h0000;
    endtask

    task automatic model_frame(input logic [15:0] w, output bit exp_strobe, output bit exp_pop);
        int op = int'(w[15:12]);
        int a  = int'(w[11:8]);
        exp_strobe = 0; exp_pop = 0;
        if (op == 0) m_resp = 16'h0000;
        else if (op == 1 && a < NR) begin
            m_regs[a] = w[7:0]; m_wr_addr = w[11:8]; m_resp = w;
            exp_strobe = 1; m_strobes++;
        end else if (op == 2 && a < NR) m_resp = {4'h2, w[11:8], m_regs[a]};
        else if (op == 3) begin
            if (fifo_valid) begin m_resp = fifo_data; exp_pop = 1; m_pops++; end
            else begin m_resp = 16'h0000; m_err = 1'b1; end
        end else if (op == 4) begin
            m_resp = {15'h0, m_err}; m_err = 1'b0;
        end else begin
            m_resp = 16'hDEAD; m_err = 1'b1;
        end
        m_fc = m_fc + 8'd1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".regs"}, cfg_regs, m_flat());
        check({tag, ".err"}, err_flag, m_err);
        check({tag, ".fc"}, frame_count, m_fc);
        check({tag, ".wraddr"}, cfg_wr_addr, m_wr_addr);
    endtask

    // Full frame: checks the previous reply on miso, then the executed effects.
    task automatic send_frame(input logic [15:0] w, input string tag);
        logic [15:0] got;
        bit es, ep;
        for (int i = 15; i >= 0; i--) begin
            @(negedge sclk);
            ss = 1'b0; mosi = w[i]; got[i] = miso;
        end
        check({tag, ".miso"}, got, m_resp);
        model_frame(w, es, ep);
        @(negedge sclk);
        ss = 1'b1;
        check({tag, ".strobe"}, cfg_wr_strobe, es);
        check({tag, ".pop"}, fifo_pop, ep);
        @(negedge sclk);
        check({tag, ".strobe_off"}, cfg_wr_strobe, 1'b0);
        check({tag, ".pop_off"}, fifo_pop, 1'b0);
        check({tag, ".nstrobe"}, seen_strobes, m_strobes);
        check({tag, ".npop"}, seen_pops, m_pops);
        check_state(tag);
    endtask

    task automatic send_partial(input logic [15:0] w, input int nbits, input bit do_abort);
        for (int i = 15; i > 15 - nbits; i--) begin
            @(negedge sclk);
            ss = 1'b0; mosi = w[i];
        end
        if (do_abort) begin
            @(negedge sclk);
            ss = 1'b1;
            m_resp = 16'h0000;
            @(negedge sclk);
        end
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        model_reset();
        #1;
        check({tag, ".miso"}, miso, 1'b0);
        check({tag, ".strobe"}, cfg_wr_strobe, 1'b0);
        check({tag, ".pop"}, fifo_pop, 1'b0);
        check_state(tag);
        @(negedge sclk);
        ss = 1'b1;
        @(negedge sclk);
        rst = 1'b1;
        @(negedge sclk);
    endtask

    initial begin
        logic [15:0] w;
        model_reset();
        m_strobes = 0; m_pops = 0;
        ss = 1'b1; mosi = 1'b0; fifo_valid = 1'b0; fifo_data = 16'h0000;
        rst = 1'b1;
        @(negedge sclk);
        apply_reset("rst0");

        send_frame(16'h135A, "wr3");
        check("reg3", cfg_regs[31:24], 8'h5A);
        send_frame(16'h0000, "nop_after_wr");
        send_frame(16'h135A, "wr3b");
        send_frame(16'h2300, "rd3");
        send_frame(16'h0000, "nop_after_rd");

        fifo_valid = 1'b1; fifo_data = 16'hBEEF;
        send_frame(16'h3000, "stream_ok");
        send_frame(16'h0000, "nop_after_stream");
        fifo_valid = 1'b0;
        send_frame(16'h3000, "stream_under");
        send_frame(16'h0000, "nop_after_under");

        send_frame(16'hF000, "bad_op");
        send_frame(16'h4000, "clear");
        send_frame(16'h0000, "nop_after_clear");
        send_frame(16'h1955, "wr_oob");
        send_frame(16'h2A00, "rd_oob");
        send_frame(16'h4000, "clear2");

        send_partial(16'h1AAA, 7, 1'b1);
        send_frame(16'h1211, "after_abort");
        check("reg2", cfg_regs[23:16], 8'h11);

        send_partial(16'h1477, 10, 1'b0);
        @(negedge sclk);
        apply_reset("rst_mid");
        send_frame(16'h1699, "after_rst");

        for (int n = 0; n < 300; n++) begin
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(0, 6));
            fifo_valid = 1'($urandom_range(0, 1));
            fifo_data  = 16'($urandom);
            if ($urandom_range(0, 19) == 0) send_partial(w, $urandom_range(1, 15), 1'b1);
            else send_frame(w, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_pll_cfg_sequencer.md
Name: spi_pll_cfg_sequencer

Overview:
- Command sequencer for the PLL SPI slave, clocked entirely on sclk.
- Deserialises 16-bit MOSI frames and decodes each as {opcode[15:12], addr[11:8], data[7:0]}.
- Executes writes to a small PLL configuration register bank.
- Schedules the MISO response for the next frame, selecting between register readback, a FIFO sample stream and status codes.

Parameters:
- NUM_REGS, 8, number of 8-bit config registers (1..16).
- CFG_RESET, 8'h00, reset value of every config register.

Ports:
- rst  input  1  asynchronous reset, active-low.
- sclk  input  1  SPI clock; all state updates on posedge sclk.
- ss  input  1  slave select, active-low, sampled on posedge sclk.
- mosi  input  1  serial data in, MSB first, sampled on posedge sclk.
- miso  output  1  serial data out; equals resp_shift[15].
- fifo_data  input  16  sample word offered by the capture FIFO.
- fifo_valid  input  1  fifo_data is valid.
- fifo_pop  output  1  one-sclk pulse when fifo_data is consumed.
- cfg_regs  output  NUM_REGS*8  flattened register bank; reg i occupies bits [8i+7:8i].
- cfg_wr_strobe  output  1  one-sclk pulse on a successful register write.
- cfg_wr_addr  output  4  address of the last successful write.
- err_flag  output  1  sticky error flag.
- frame_count  output  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset (rst low, asynchronous) clears the following:
  - FSM to IDLE; bit_cnt=0; rx_shift=0; resp_shift=0, so miso=0.
  - All cfg_regs=CFG_RESET.
  - fifo_pop, cfg_wr_strobe, cfg_wr_addr, err_flag and frame_count all 0.
  - A frame in progress when rst asserts is discarded.
- FSM state IDLE:
  - While ss=1, bit_cnt=0 and resp_shift holds its value.
  - The first posedge with ss=0 samples bit 0, sets bit_cnt=1 and moves to SHIFT.
- FSM state SHIFT, each posedge with ss=0:
  - rx_shift <= {rx_shift[14:0], mosi}; bit_cnt increments.
  - On bits 0..14, resp_shift shifts left by 1 and fills with 0.
- Frame completion is the posedge that samples bit 15 (bit_cnt==15):
  - frame = {rx_shift[14:0], mosi}.
  - Decode and execute on that same edge.
  - resp_shift is loaded with the next response, so miso shows its MSB before the next frame's first edge.
  - bit_cnt returns to 0; FSM returns to IDLE; frame_count increments.
- Abort: a posedge with ss=1 while in SHIFT discards the partial frame.
  - bit_cnt=0, resp_shift=0, FSM to IDLE.
  - No execution and no frame_count increment.
- Opcodes:
  - 0x0 NOP: response 16'h0000.
  - 0x1 WRITE: if addr<NUM_REGS, reg[addr]<=data, cfg_wr_addr<=addr, cfg_wr_strobe=1 for one cycle, response {4'h1, addr, data}. Otherwise no write, err_flag<=1, response 16'hDEAD.
  - 0x2 READ: if addr<NUM_REGS, response {4'h2, addr, reg[addr]}. Otherwise err_flag<=1, response 16'hDEAD.
  - 0x3 STREAM: if fifo_valid=1, response fifo_data and fifo_pop=1 for one cycle. Otherwise response 16'h0000 and err_flag<=1 (underflow).
  - 0x4 CLEAR: err_flag<=0; response {15'h0, err_flag_old}.
  - Other opcodes: err_flag<=1; response 16'hDEAD.
- Write-then-read of the same register in consecutive frames returns the new value.
- fifo_pop and cfg_wr_strobe are registered and are never high for more than one sclk.
- A single frame never asserts both fifo_pop and cfg_wr_strobe.
- Error precedence:
  - err_flag set and CLEAR can never coincide in one frame.
  - Error conditions set err_flag regardless of its current value.
- The response of frame N is shifted out during frame N+1.
  - The frame immediately after reset or after an abort returns 16'h0000.

Test Plan:
- Reset, then frame 0x135A -> cfg_regs[31:24]=0x5A, cfg_wr_strobe single pulse, cfg_wr_addr=3, frame_count=1; next frame (NOP 0x0000) shifts out 0x135A on miso.
- Frames 0x135A, 0x2300, 0x0000 -> during the third frame, miso shifts 0x235A MSB-first.
- fifo_valid=1, fifo_data=0xBEEF, frame 0x3000 -> fifo_pop pulses exactly once at bit 15; next frame shifts 0xBEEF. Repeat with fifo_valid=0 -> no pop, response 0x0000, err_flag=1.
- Frame 0xF000 -> err_flag=1, next response 0xDEAD; frame 0x4000 -> err_flag=0; following frame returns 0x0001. Frame 0x1955 with NUM_REGS=8 -> no write, no strobe, err_flag=1.
- Abort: send 7 bits of 0x1AAA, raise ss for one edge, then send full 0x1211 -> only reg2=0x11 written, frame_count increments by 1, reg10 untouched.
- Assert rst mid-frame after 10 bits of a WRITE -> all regs back to CFG_RESET, no strobe; a subsequent clean frame executes normally.
